// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - fetch, write-back and execute-side signals of the decode stage
interface decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_regsel;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_read1data;
    logic [XLEN-1:0] out_read2data;
    logic [XLEN-1:0] out_imm_ext;
    logic [3:0]      out_alu_op;
    logic            out_jump;
    logic            out_branch;
    logic            out_imm_sel;
    logic            out_wb_sel;
    logic            out_mem_write;
    logic            out_write;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, flush, wb_en, wb_regsel, wb_data, out_ready,
        output in_ready, out_valid, out_read1data, out_read2data, out_imm_ext,
               out_alu_op, out_jump, out_branch, out_imm_sel, out_wb_sel,
               out_mem_write, out_write, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, flush, wb_en, wb_regsel, wb_data, out_ready,
        input  in_ready, out_valid, out_read1data, out_read2data, out_imm_ext,
               out_alu_op, out_jump, out_branch, out_imm_sel, out_wb_sel,
               out_mem_write, out_write, out_rd, out_illegal
    );
endinterface

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage: register file, control decode, immediate extend, RAW scoreboard
// Macro DECODE_WB_BYPASS_EN forwards same-cycle write-back into captured operands.
module decode_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input logic          clk,
    input logic          rst,
    decode_pipe_if.slave bus
);
    localparam int IW = $clog2(NUM_REGS);

    typedef struct packed {
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic            jump;
        logic            branch;
        logic            imm_sel;
        logic            wb_sel;
        logic            mem_write;
        logic            write;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    // Register fields above NUM_REGS alias back into the file.
    function automatic logic [IW-1:0] ridx(input logic [4:0] f);
        return IW'(32'(f) % 32'(NUM_REGS));
    endfunction

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    bundle_t             q;
    bundle_t             d;
    logic                q_valid;

    logic [31:0]   instr;
    logic [2:0]    cls;
    logic [14:0]   imm15;
    logic [IW-1:0] s1, s2, wbi, out_ri;
    logic          c_reg, c_imm, c_load, c_store, c_branch, c_jump, legal;
    logic          use1, use2, busy1, busy2, in_flight, haz1, haz2, hazard;
    logic          ready, accept;

    assign instr  = bus.in_instr;
    assign cls    = instr[31:29];
    assign s1     = ridx(instr[19:15]);
    assign s2     = ridx(instr[14:10]);
    assign wbi    = ridx(bus.wb_regsel);
    assign out_ri = ridx(q.rd);

    assign c_reg    = (cls == 3'd0);
    assign c_imm    = (cls == 3'd1);
    assign c_load   = (cls == 3'd2);
    assign c_store  = (cls == 3'd3);
    assign c_branch = (cls == 3'd4);
    assign c_jump   = (cls == 3'd5);
    assign legal    = ~(cls[2] & cls[1]);

    assign use1  = legal & ~c_jump;
    assign use2  = c_reg | c_store | c_branch;
    assign imm15 = (c_store | c_branch) ? {instr[24:20], instr[9:0]} : instr[14:0];

    always_comb begin
        busy1 = sb[s1];
        busy2 = sb[s2];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && wbi == s1) busy1 = 1'b0;
        if (bus.wb_en && wbi == s2) busy2 = 1'b0;
`endif
    end

    // The bundle sitting in the output register has not yet reached the scoreboard.
    assign in_flight = q_valid & q.write;
    assign haz1      = use1 && (s1 != '0) && (busy1 || (in_flight && s1 == out_ri));
    assign haz2      = use2 && (s2 != '0) && (busy2 || (in_flight && s2 == out_ri));
    assign hazard    = haz1 | haz2;

    assign ready  = !rst && !bus.flush && !hazard && (!q_valid || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_comb begin
        d           = '0;
        d.r1        = (s1 == '0) ? '0 : regs[s1];
        d.r2        = (s2 == '0) ? '0 : regs[s2];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && wbi != '0 && wbi == s1) d.r1 = bus.wb_data;
        if (bus.wb_en && wbi != '0 && wbi == s2) d.r2 = bus.wb_data;
`endif
        d.imm       = {{(XLEN-15){imm15[14]}}, imm15};
        d.alu       = instr[28:25];
        d.rd        = instr[24:20];
        d.write     = c_reg | c_imm | c_load | c_jump;
        d.imm_sel   = c_imm | c_load | c_store;
        d.wb_sel    = c_load;
        d.mem_write = c_store;
        d.branch    = c_branch;
        d.jump      = c_jump;
        d.illegal   = ~legal;
    end

    // Set after clear so a completing writer wins over a same-register write-back.
    always_comb begin
        sb_next = sb;
        if (bus.wb_en) sb_next[wbi] = 1'b0;
        if (q_valid && bus.out_ready && q.write && out_ri != '0 && !bus.flush)
            sb_next[out_ri] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
            sb      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (bus.wb_en && wbi != '0) regs[wbi] <= bus.wb_data;
            sb <= sb_next;
            if (accept) begin
                q_valid <= 1'b1;
                q       <= d;
            end else if (bus.flush || bus.out_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = ready;
    assign bus.out_valid     = q_valid;
    assign bus.out_read1data = q.r1;
    assign bus.out_read2data = q.r2;
    assign bus.out_imm_ext   = q.imm;
    assign bus.out_alu_op    = q.alu;
    assign bus.out_jump      = q.jump;
    assign bus.out_branch    = q.branch;
    assign bus.out_imm_sel   = q.imm_sel;
    assign bus.out_wb_sel    = q.wb_sel;
    assign bus.out_mem_write = q.mem_write;
    assign bus.out_write     = q.write;
    assign bus.out_rd        = q.rd;
    assign bus.out_illegal   = q.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - self-checking bench for decode_pipe with a behavioural reference model
module tb_decode_pipe;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic            jump;
        logic            branch;
        logic            imm_sel;
        logic            wb_sel;
        logic            mem_write;
        logic            write;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [XLEN-1:0] m_regs [NUM_REGS];
    bit              m_busy [NUM_REGS];
    bundle_t         m_out;

    always #5 clk = ~clk;

    decode_pipe_if #(.XLEN(XLEN)) bus ();
    decode_pipe #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic int ai(input logic [4:0] f);
        return int'(f) % NUM_REGS;
    endfunction

    function automatic logic [XLEN-1:0] read_ref(input logic [4:0] f);
        int i = ai(f);
        if (i == 0) return '0;
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && ai(bus.wb_regsel) == i) return bus.wb_data;
`endif
        return m_regs[i];
    endfunction

    function automatic bundle_t decode_ref(input logic [31:0] w);
        bundle_t     b = '0;
        logic [2:0]  cls = w[31:29];
        logic [14:0] imm15;
        imm15   = (cls == 3'd3 || cls == 3'd4) ? {w[24:20], w[9:0]} : w[14:0];
        b.valid = 1'b1;
        b.r1    = read_ref(w[19:15]);
        b.r2    = read_ref(w[14:10]);
        b.imm   = XLEN'($signed(imm15));
        b.alu   = w[28:25];
        b.rd    = w[24:20];
        case (cls)
            3'd0: b.write = 1'b1;
            3'd1: begin b.write = 1'b1; b.imm_sel = 1'b1; end
            3'd2: begin b.write = 1'b1; b.imm_sel = 1'b1; b.wb_sel = 1'b1; end
            3'd3: begin b.imm_sel = 1'b1; b.mem_write = 1'b1; end
            3'd4: b.branch = 1'b1;
            3'd5: begin b.write = 1'b1; b.jump = 1'b1; end
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    function automatic bit src_blocked(input logic [4:0] f);
        int i = ai(f);
        bit busy;
        if (i == 0) return 1'b0;
        busy = m_busy[i];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.wb_en && ai(bus.wb_regsel) == i) busy = 1'b0;
`endif
        if (m_out.valid && m_out.write && ai(m_out.rd) == i) busy = 1'b1;
        return busy;
    endfunction

    function automatic logic exp_ready();
        logic [2:0] cls = bus.in_instr[31:29];
        if (rst || bus.flush) return 1'b0;
        if (m_out.valid && !bus.out_ready) return 1'b0;
        if (cls <= 3'd4 && src_blocked(bus.in_instr[19:15])) return 1'b0;
        if ((cls == 3'd0 || cls == 3'd3 || cls == 3'd4) && src_blocked(bus.in_instr[14:10])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bundle_t dut_bundle();
        return {bus.out_valid, bus.out_read1data, bus.out_read2data, bus.out_imm_ext,
                bus.out_alu_op, bus.out_jump, bus.out_branch, bus.out_imm_sel,
                bus.out_wb_sel, bus.out_mem_write, bus.out_write, bus.out_rd, bus.out_illegal};
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] cls, input logic [3:0] alu,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [14:0] low);
        return {cls, alu, rd, rs1, low};
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_regsel = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        logic    acc;
        logic    hs;
        bundle_t nb;
        acc = bus.in_valid && exp_ready();
        nb  = decode_ref(bus.in_instr);
        hs  = m_out.valid && bus.out_ready && m_out.write && ai(m_out.rd) != 0 && !bus.flush;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_out = '0;
        end else begin
            if (bus.wb_en) begin
                m_busy[ai(bus.wb_regsel)] = 1'b0;
                if (ai(bus.wb_regsel) != 0) m_regs[ai(bus.wb_regsel)] = bus.wb_data;
            end
            if (hs) m_busy[ai(m_out.rd)] = 1'b1;
            if (acc) m_out = nb;
            else if (bus.flush || bus.out_ready) m_out.valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd1, 4'h3, 5'd1, 5'd0, 15'h11);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        idle();
        n_cmp++;
        if (dut_bundle() !== bundle_t'('0)) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", dut_bundle());
        end
    endtask

    task automatic test_basic_imm();
        bundle_t b;
        do_reset();
        bus.wb_en = 1'b1; bus.wb_regsel = 5'd3; bus.wb_data = 32'h0000_1234;
        tick();
        idle();
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd1, 4'h2, 5'd5, 5'd3, 15'h7FFF);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
        idle();
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.r1, b.imm, b.imm_sel, b.write, b.rd} !==
            {1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd5}) begin
            n_bad++; $display("FAIL basic_imm_alu: got %h want imm-ALU rd5 r1=1234 imm=ffffffff", b);
        end
    endtask

    task automatic test_branch();
        bundle_t b;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd4, 4'h0, 5'h10, 5'd0, 15'h0);
        tick();
        idle();
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.imm, b.branch, b.write} !== {1'b1, 32'hFFFF_C000, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL branch_imm: got %h want imm=ffffc000 branch=1 write=0", b);
        end
    endtask

    task automatic test_raw_stall();
        bundle_t b;
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd2, 4'h0, 5'd7, 5'd0, 15'h4);
        tick();
        bus.in_instr = mk(3'd0, 4'h1, 5'd8, 5'd0, {5'd7, 10'h0});
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_bad++; $display("FAIL raw_stall_%0d: got in_ready=%b want 0", c, bus.in_ready);
            end
            tick();
        end
        bus.wb_en = 1'b1; bus.wb_regsel = 5'd7; bus.wb_data = 32'h0000_00A5;
        #1;
        n_cmp++;
`ifdef DECODE_WB_BYPASS_EN
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL raw_wb_cycle: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        idle();
`else
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL raw_wb_cycle: got in_ready=%b want 0", bus.in_ready);
        end
        tick();
        bus.wb_en = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL raw_after_wb: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        idle();
`endif
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.r2, b.rd} !== {1'b1, 32'h0000_00A5, 5'd8}) begin
            n_bad++; $display("FAIL raw_operand: got %h want r2=a5 rd=8", b);
        end
    endtask

    task automatic test_hold();
        bundle_t     b;
        logic [14:0] imm_a;
        logic [14:0] imm_b;
        imm_a = 15'($urandom);
        imm_b = 15'($urandom);
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(3'd1, 4'h4, 5'd1, 5'd0, imm_a);
        tick();
        bus.in_instr = mk(3'd1, 4'h5, 5'd2, 5'd0, imm_b);
        for (int c = 0; c < 3; c++) begin
            #1;
            b = dut_bundle();
            n_cmp++;
            if ({bus.in_ready, b.valid, b.rd, b.imm, b.alu} !==
                {1'b0, 1'b1, 5'd1, {{17{imm_a[14]}}, imm_a}, 4'h4}) begin
                n_bad++; $display("FAIL hold_%0d: in_ready=%b bundle %h want held rd1", c, bus.in_ready, b);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL hold_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.rd, b.imm, b.alu} !== {1'b1, 5'd2, {{17{imm_b[14]}}, imm_b}, 4'h5}) begin
            n_bad++; $display("FAIL hold_next: got %h want rd2 bundle", b);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL hold_drain: got out_valid=%b want 0", bus.out_valid);
        end
        idle();
    endtask

    task automatic test_flush_illegal();
        bundle_t b;
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(3'd1, 4'h0, 5'd9, 5'd0, 15'h21);
        tick();
        bus.flush    = 1'b1;
        bus.in_instr = mk(3'd1, 4'h0, 5'd11, 5'd0, 15'h22);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_drop: got out_valid=%b want 0", bus.out_valid);
        end
        bus.in_instr = mk(3'd1, 4'h0, 5'd10, 5'd9, 15'h1);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_no_stall: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.rd, b.r1} !== {1'b1, 5'd10, 32'h0}) begin
            n_bad++; $display("FAIL flush_next: got %h want rd10 r1=0", b);
        end
        bus.in_instr = {3'b111, 4'hF, 5'd12, 5'd0, 15'h7FFF};
        tick();
        idle();
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.illegal, b.jump, b.branch, b.imm_sel, b.wb_sel, b.mem_write, b.write} !==
            {1'b1, 1'b1, 6'b0}) begin
            n_bad++; $display("FAIL illegal_op: got %h want illegal=1 controls=0", b);
        end
    endtask

    task automatic test_reset_mid();
        bundle_t b;
        do_reset();
        bus.wb_en = 1'b1; bus.wb_regsel = 5'd2; bus.wb_data = 32'h55;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd2, 4'h0, 5'd4, 5'd0, 15'h0);
        tick();
        bus.wb_en    = 1'b0;
        bus.in_instr = mk(3'd1, 4'h0, 5'd6, 5'd0, 15'h5);
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL midreset_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        rst = 1'b0;
        idle();
        n_cmp++;
        if (dut_bundle() !== bundle_t'('0)) begin
            n_bad++; $display("FAIL midreset_outputs: got %h want 0", dut_bundle());
        end
        bus.wb_en = 1'b1; bus.wb_regsel = 5'd0; bus.wb_data = 32'hDEAD;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(3'd0, 4'h0, 5'd1, 5'd4, {5'd2, 10'h0});
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midreset_sb_clear: got in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.wb_en    = 1'b0;
        bus.in_instr = mk(3'd0, 4'h0, 5'd3, 5'd0, 15'h0);
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.r1, b.r2} !== {1'b1, 32'h0, 32'h0}) begin
            n_bad++; $display("FAIL midreset_regs: got %h want r1=0 r2=0", b);
        end
        tick();
        idle();
        b = dut_bundle();
        n_cmp++;
        if ({b.valid, b.r1, b.r2} !== {1'b1, 32'h0, 32'h0}) begin
            n_bad++; $display("FAIL r0_reads_zero: got %h want r1=0 r2=0", b);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                w[24:23] = 2'b00;
                w[19:18] = 2'b00;
                w[14:13] = 2'b00;
            end
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_instr  = w;
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_en     = ($urandom_range(0, 2) == 0);
            bus.wb_regsel = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            #1;
            n_cmp++;
            if (bus.in_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rand_in_ready @%0d: got %b want %b", n, bus.in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== m_out.valid || (m_out.valid && dut_bundle() !== m_out)) begin
                n_bad++; $display("FAIL rand_bundle @%0d: got %h want %h", n, dut_bundle(), m_out);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_basic_imm();
        test_branch();
        test_raw_stall();
        test_hold();
        test_flush_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, pipelined decode stage for the 32-bit instruction format: op[31:25], rd[24:20], rs1[19:15], rs2[14:10], imm[14:0].
- Contains the register file, opcode control decode and the immediate extender.
- Adds a registered output stage with valid/ready handshakes, a per-register pending-write scoreboard for RAW stalls, and flush.
- Sits between fetch (upstream) and execute (downstream); write-back drives the wb_* port.

Parameters:
XLEN, 32, datapath/register width (16..64); immediate sign-extended to XLEN
NUM_REGS, 32, architectural registers (2..32); reg 0 reads zero, writes ignored; higher indices alias modulo NUM_REGS

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents in_instr
in_ready  out  1  decode accepts in_instr this cycle
in_instr  in  32  instruction word
flush  in  1  kill held and incoming instruction
wb_en  in  1  register write strobe
wb_regsel  in  5  write-back destination
wb_data  in  XLEN  write-back data
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_read1data, out_read2data  out  XLEN  rs1/rs2 operands
out_imm_ext  out  XLEN  sign-extended immediate
out_alu_op  out  4  op[28:25]
out_jump, out_branch, out_imm_sel, out_wb_sel, out_mem_write, out_write  out  1 each  control bits
out_rd  out  5  destination register
out_illegal  out  1  undefined class

Behaviour:
- Class = op[31:29]:
  - 000 reg-ALU; 001 imm-ALU; 010 load; 011 store; 100 branch; 101 jump; 110/111 illegal.
  - Illegal: all control bits 0 and out_illegal=1.
- Control decode:
  - write = 000/001/010/101.
  - imm_sel = 001/010/011.
  - wb_sel = 010.
  - mem_write = 011.
  - branch = 100; jump = 101.
- Immediate: branch/store use {instr[24:20],instr[9:0]}; all other classes use instr[14:0]. Sign-extend bit 14 to XLEN.
- Source use:
  - rs1 used by all legal classes except jump.
  - rs2 used by 000, 011 and 100.
  - Register 0 never hazards.
- Scoreboard (NUM_REGS bits):
  - Set bit rd when a write-class bundle completes the output handshake (out_valid & out_ready) with rd≠0.
  - Clear bit wb_regsel on wb_en.
  - Same-cycle set and clear of the same register: set wins.
- hazard = a used source has its scoreboard bit set, OR equals out_rd while out_valid & out_write.
- in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready. Next cycle: out_valid=1 and the bundle is registered. Latency is 1 cycle.
- Hold: while out_valid & !out_ready, all out_* stay stable.
- Drain without refill: out_valid=0 next cycle.
- Flush: out_valid=0 next cycle; the held bundle is dropped and never sets the scoreboard. Register file and scoreboard are unaffected. Write-back in the same cycle still commits.
- Register file:
  - Written on wb_en at the clock edge.
  - Reads are combinational from in_instr and captured at accept.
- Reset, synchronous, may occur mid-operation:
  - out_valid=0; all out_* = 0.
  - Scoreboard cleared; all registers = 0.
  - in_ready=0 during the reset cycle.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined:
  - A same-cycle wb_en write to a used source forwards wb_data into the captured operand.
  - The scoreboard bit being cleared that cycle counts as not busy, so a dependent instruction issues the same cycle as its write-back.
- Undefined:
  - No forwarding; the cleared bit is seen next cycle, so the dependent instruction stalls one extra cycle.
- Both builds are functionally correct; only stall counts differ.

Test Plan:
1. Reset, wb write r3=0x0000_1234, then imm-ALU rd=5 rs1=3 imm=0x7FFF -> one cycle later: out_valid=1, read1data=0x1234, imm_ext=0xFFFF_FFFF, imm_sel=1, write=1, rd=5.
2. Branch with instr[24:20]=5'h10, instr[9:0]=0 -> imm_ext=0xFFFF_C000, branch=1, write=0.
3. Issue load rd=7, then reg-ALU with rs2=7 -> in_ready=0 until wb_en rd=7 data=0xA5:
   - with DECODE_WB_BYPASS_EN: accepted in the wb cycle, read2data=0xA5;
   - without it: accepted the cycle after.
4. Hold out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0; release -> next instruction appears the following cycle, no loss or duplication.
5. Flush while a bundle for rd=9 is held -> out_valid=0 next cycle; a subsequent instruction reading r9 is not stalled; an illegal op 3'b111 -> out_illegal=1, all controls 0.
6. Assert rst with out_valid=1 and scoreboard bits set -> next cycle all outputs 0 and scoreboard clear; wb write to r0 then read r0 -> 0.
